// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the processor control path and the
// memory access unit: valid/ready request channel plus a one-cycle
// response pulse with load data and an error flag.
//
// Signals:
//   req_valid  - request present (master -> slave)
//   req_ready  - slave can accept this cycle (slave -> master)
//   req_op     - 00 load, 01 store, 10 fill, 11 reserved
//   req_addr   - load/store target address
//   req_wdata  - store/fill value
//   resp_valid - one-cycle completion pulse
//   resp_data  - load result, zero for other ops
//   resp_err   - asserted with resp_valid for the reserved op
interface mem_access_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Controller in front of a 2^ADDR_W x DATA_W data memory: runs single
// loads/stores, whole-memory fills and flags reserved ops as errors.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bus          - request/response channel (slave side)
//   busy         - high whenever the unit is not idle
//   M_add, M_wd  - memory address and write data
//   M_we, M_re   - memory write / read enables
//   M_rd         - combinational memory read data
module mem_access_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_unit_if.slave  bus,
    output logic              busy,
    output logic [ADDR_W-1:0] M_add,
    output logic [DATA_W-1:0] M_wd,
    output logic              M_we,
    output logic              M_re,
    input  logic [DATA_W-1:0] M_rd
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    // Only an idle unit with ready already registered high can take a
    // request; valid in any other state is simply dropped.
    assign accept = (state_q == IDLE) && ready_q && bus.req_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    unique case (bus.req_op)
                        OP_LOAD,
                        OP_STORE: state_d = ACCESS;
                        OP_FILL: begin
                            state_d = FILL;
                            cnt_d   = '0;
                        end
                        OP_RSVD: begin
                            state_d = RESP;
                            rdata_d = '0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Load data is taken at the edge that ends the access.
                rdata_d = (op_q == OP_LOAD) ? M_rd : '0;
            end
            FILL: begin
                // Counter wraps to zero on the last write.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered ready: high after any edge that lands in IDLE.
        ready_d = (state_d == IDLE);
    end

    // Memory pins decode from state and latched fields only.
    always_comb begin
        M_add = '0;
        M_wd  = '0;
        M_we  = 1'b0;
        M_re  = 1'b0;
        unique case (state_q)
            ACCESS: begin
                M_add = addr_q;
                if (op_q == OP_LOAD) begin
                    M_re = 1'b1;
                end else begin
                    M_we = 1'b1;
                    M_wd = wdata_q;
                end
            end
            FILL: begin
                M_add = cnt_q;
                M_wd  = wdata_q;
                M_we  = 1'b1;
            end
            default: begin
                M_add = '0;
            end
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && (op_q == OP_RSVD);
    assign bus.resp_data  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 16x4 memory.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_mem_access_unit;

    logic       clk;
    logic       reset_n;
    logic       busy;
    logic [3:0] M_add;
    logic [3:0] M_wd;
    logic       M_we;
    logic       M_re;
    logic [3:0] M_rd;

    logic [3:0] mem [16];
    logic       init_req;

    int total;
    int bad;

    mem_access_unit_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    mem_access_unit #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .busy    (busy),
        .M_add   (M_add),
        .M_wd    (M_wd),
        .M_we    (M_we),
        .M_re    (M_re),
        .M_rd    (M_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
        end else if (M_we) begin
            mem[M_add] <= M_wd;
        end
    end

    assign M_rd = mem[M_add];

    task automatic init_mem();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    // Waits (bounded) for ready, presents one request, returns just
    // after the accepting edge T, i.e. at the start of cycle T+1.
    task automatic send(input logic [1:0] op, input logic [3:0] addr,
                        input logic [3:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=%b want=1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b11;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wd;
    endtask

    task automatic do_load(input logic [3:0] addr, output logic [3:0] d);
        send(2'b00, addr, 4'h0);
        @(negedge clk);
        @(negedge clk);
        d = bus.resp_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, busy, bus.resp_valid, bus.resp_err}
            !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0000",
                     {bus.req_ready, busy, bus.resp_valid, bus.resp_err});
        end
        total++;
        if ({M_we, M_re, M_add, M_wd, bus.resp_data} !== 14'h0) begin
            bad++;
            $display("FAIL reset_mem got=%h want=0",
                     {M_we, M_re, M_add, M_wd, bus.resp_data});
        end
        init_mem();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_pre_edge got=%b want=0", bus.req_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_post_edge got=%b want=1", bus.req_ready);
        end
    endtask

    task automatic test_load();
        send(2'b00, 4'd5, 4'h0);
        @(negedge clk);
        total++;
        if ({M_re, M_we, M_add, bus.resp_valid, busy} !== 8'b1_0_0101_0_1)
        begin
            bad++;
            $display("FAIL load_access got=%b want=10010101",
                     {M_re, M_we, M_add, bus.resp_valid, busy});
        end
        @(negedge clk);
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_data, M_re}
            !== 7'b1_0_0101_0) begin
            bad++;
            $display("FAIL load_resp got=%b want=1001010",
                     {bus.resp_valid, bus.resp_err, bus.resp_data, M_re});
        end
        @(negedge clk);
        total++;
        if ({bus.resp_valid, bus.req_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL load_idle got=%b want=010",
                     {bus.resp_valid, bus.req_ready, busy});
        end
    endtask

    task automatic test_store();
        logic [3:0] d;
        send(2'b01, 4'd3, 4'hA);
        @(negedge clk);
        total++;
        if ({M_we, M_re, M_add, M_wd} !== 10'b1_0_0011_1010) begin
            bad++;
            $display("FAIL store_access got=%b want=1000111010",
                     {M_we, M_re, M_add, M_wd});
        end
        @(negedge clk);
        total++;
        if ({M_we, bus.resp_valid, bus.resp_data} !== 6'b0_1_0000) begin
            bad++;
            $display("FAIL store_resp got=%b want=010000",
                     {M_we, bus.resp_valid, bus.resp_data});
        end
        do_load(4'd3, d);
        total++;
        if (d !== 4'hA) begin
            bad++;
            $display("FAIL store_readback got=%h want=a", d);
        end
    endtask

    task automatic test_fill();
        logic [3:0] d;
        int errs;
        errs = 0;
        send(2'b10, 4'd9, 4'h7);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!(M_we === 1'b1 && M_add === 4'(i) && M_wd === 4'h7 &&
                  bus.resp_valid === 1'b0)) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL fill_writes got=%0d bad cycles want=0", errs);
        end
        @(negedge clk);
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_data, M_we}
            !== 7'b1_0_0000_0) begin
            bad++;
            $display("FAIL fill_resp got=%b want=1000000",
                     {bus.resp_valid, bus.resp_err, bus.resp_data, M_we});
        end
        do_load(4'd0, d);
        total++;
        if (d !== 4'h7) begin
            bad++;
            $display("FAIL fill_addr0 got=%h want=7", d);
        end
        do_load(4'd15, d);
        total++;
        if (d !== 4'h7) begin
            bad++;
            $display("FAIL fill_addr15 got=%h want=7", d);
        end
    endtask

    task automatic test_reserved();
        send(2'b11, 4'd4, 4'h5);
        @(negedge clk);
        total++;
        if ({bus.resp_valid, bus.resp_err, busy, M_we, M_re,
             bus.resp_data} !== 9'b1_1_1_0_0_0000) begin
            bad++;
            $display("FAIL rsvd_resp got=%b want=111000000",
                     {bus.resp_valid, bus.resp_err, busy, M_we, M_re,
                      bus.resp_data});
        end
        @(negedge clk);
        total++;
        if ({bus.resp_valid, bus.resp_err, busy, bus.req_ready}
            !== 4'b0001) begin
            bad++;
            $display("FAIL rsvd_after got=%b want=0001",
                     {bus.resp_valid, bus.resp_err, busy, bus.req_ready});
        end
    endtask

    task automatic test_back_to_back();
        int nresp;
        int n;
        nresp = 0;
        n = 0;
        init_mem();
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_addr  = 4'd9;
        bus.req_wdata = 4'h0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (bus.req_ready !== (c % 3 == 0)) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b want=%b",
                         c, bus.req_ready, (c % 3 == 0));
            end
            if (bus.resp_valid === 1'b1) begin
                nresp++;
                total++;
                if (bus.resp_data !== 4'd9 || c % 3 != 2) begin
                    bad++;
                    $display("FAIL b2b_resp c=%0d got=%h want=9",
                             c, bus.resp_data);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 10; c < 14; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                nresp++;
                total++;
                if (bus.resp_data !== 4'd9 || c != 11) begin
                    bad++;
                    $display("FAIL b2b_tail c=%0d got=%h want=9",
                             c, bus.resp_data);
                end
            end
        end
        total++;
        if (nresp !== 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", nresp);
        end
    endtask

    task automatic test_fill_abort();
        logic [3:0] d;
        int errs;
        errs = 0;
        init_mem();
        send(2'b10, 4'd0, 4'h2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (!(M_we === 1'b1 && M_add === 4'(k - 1))) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL abort_prefill got=%0d bad cycles want=0", errs);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({M_we, M_re, M_add, M_wd, busy, bus.req_ready,
             bus.resp_valid, bus.resp_err} !== 14'h0) begin
            bad++;
            $display("FAIL abort_reset got=%h want=0",
                     {M_we, M_re, M_add, M_wd, busy, bus.req_ready,
                      bus.resp_valid, bus.resp_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (mem[i] !== ((i < 6) ? 4'h2 : 4'(i))) begin
                bad++;
                $display("FAIL abort_mem[%0d] got=%h want=%h", i, mem[i],
                         (i < 6) ? 4'h2 : 4'(i));
            end
        end
        do_load(4'd5, d);
        total++;
        if (d !== 4'h2) begin
            bad++;
            $display("FAIL abort_load5 got=%h want=2", d);
        end
        do_load(4'd6, d);
        total++;
        if (d !== 4'h6) begin
            bad++;
            $display("FAIL abort_load6 got=%h want=6", d);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        init_req      = 1'b0;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 4'h0;
        test_reset();
        test_load();
        test_store();
        test_fill();
        test_reserved();
        test_back_to_back();
        test_fill_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request-driven controller sitting directly upstream of the 16x4 data memory. It accepts load, store and fill commands from the processor control path over a valid/ready handshake. It sequences the memory's address, write-data, write-enable and read-enable pins, and returns a one-cycle response pulse carrying load data or an error flag. Fill writes one value to every memory location using an internal address counter.

## Interface
- ADDR_W, 4, memory address width; memory depth is 2^ADDR_W.
- DATA_W, 4, memory word width.

- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a request is accepted on a rising edge with req_valid & req_ready.
- req_op  in  2  00 load, 01 store, 10 fill, 11 reserved.
- req_addr  in  ADDR_W  target address for load/store; ignored for fill.
- req_wdata  in  DATA_W  store/fill value.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DATA_W  load result; 0 for store/fill/reserved.
- resp_err  out  1  high with resp_valid for reserved op.
- busy  out  1  high in any state other than IDLE.
- M_add  out  ADDR_W  memory address.
- M_wd  out  DATA_W  memory write data.
- M_we  out  1  memory write enable; memory writes on rising clk edge.
- M_re  out  1  memory read enable; M_rd is combinational from M_add.
- M_rd  in  DATA_W  memory read data.

## Operation
- States: IDLE, ACCESS, FILL, RESP.
- On accept, latch req_op, req_addr and req_wdata into internal registers. Later changes on the req_* inputs have no effect.
- IDLE -> ACCESS on accepted load/store. IDLE -> FILL on fill (counter cleared to 0). IDLE -> RESP on reserved op.
- ACCESS, one cycle:
  - M_add = latched addr.
  - Load: M_re=1, M_we=0; M_rd captured into resp_data at the end of the cycle.
  - Store: M_we=1, M_re=0, M_wd = latched wdata.
  - Next state: RESP.
- FILL:
  - M_we=1, M_re=0, M_add = counter, M_wd = latched wdata.
  - Counter increments each cycle.
  - When counter = 2^ADDR_W-1, next state is RESP. The counter wraps to 0; no extra write occurs.
- RESP, one cycle: resp_valid=1; resp_err=1 only for the reserved op. Next state: IDLE.
- resp_data:
  - Loaded with M_rd for a load.
  - Cleared to 0 when entering RESP for store, fill or reserved.
  - Holds its value otherwise.
- Outside ACCESS/FILL: M_we=0, M_re=0, M_add=0, M_wd=0. These outputs are decoded from state and latched registers only, never directly from req_* inputs.
- req_ready is a registered output:
  - Set on every edge that leaves the unit in IDLE.
  - Cleared on accept.
  - No accept is possible in ACCESS, FILL or RESP; req_valid there is ignored and not queued.
- No response back-pressure: resp_valid is a single-cycle pulse.

## Timing
- Reset (reset_n low, effective immediately, asynchronous):
  - state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_data=0, busy=0.
  - M_we=0, M_re=0, M_add=0, M_wd=0, counter=0.
  - req_ready rises on the first rising edge after reset_n goes high.
- Accept on edge T:
  - Load/store: ACCESS during cycle T+1; write commits / read is captured at the edge ending T+1; resp_valid during T+2; req_ready high again from T+3.
  - Fill: writes addresses 0..15 ascending in cycles T+1..T+16; resp_valid during T+17; req_ready high from T+18.
  - Reserved: resp_valid=1, resp_err=1 during T+1; no memory access.
- Minimum load/store issue interval: 3 cycles.
- Reset mid-operation:
  - M_we drops immediately; no response is produced.
  - Memory contents already written stay as they are; the memory has no reset.
  - A fill aborted in cycle T+k leaves addresses 0..k-2 filled.
- Load data: resp_data equals the memory contents at the edge ending ACCESS.

## Test plan
- Memory initialised with data[i]=i; reset, then load addr 5 -> M_re high only in T+1 with M_add=5; resp_valid in T+2 with resp_data=5, resp_err=0.
- Store 0xA to addr 3, then load addr 3 -> M_we high exactly one cycle with M_add=3, M_wd=0xA; store resp_data=0; load returns 0xA.
- Fill 0x7 -> M_we high 16 consecutive cycles with M_add 0..15; resp_valid in T+17; loads of addr 0 and addr 15 return 0x7.
- req_op=11 -> resp_valid and resp_err high in T+1; M_we and M_re never asserted; busy high in T+1 only.
- req_valid held high with a fixed load request for 10 cycles -> accepted at T, T+3, T+6, T+9; exactly one response per accept; req_ready low in between.
- Fill 0x2, then reset_n low during cycle T+7 -> all outputs at reset values immediately; addresses 0..5 read 0x2 after reset, 6..15 keep their original values.
